anc_frame_scheduler: RTL
========================

Name: anc_frame_scheduler

Overview:
- Per-sample sequencer for the ANC datapath.
- On each sample-ready flag (SSPIF) from the serial ADC interface it performs, in order: writes the new sample into the circular delay-line RAM, clears the filter accumulator, steps the FIR MAC through every tap, optionally steps the LMS weight update through every tap, then strobes the DAC load.
- Sits between the SPI receive logic and the RAM/filter/DAC datapath.
- Replaces ad-hoc enable generation with a counted, overrun-checked schedule.

Parameters:
- TAPS, 32, number of filter taps; must equal 2**ADDR_W.
- ADDR_W, 5, width of the delay-line RAM address.
- SYNC_STAGES, 2, flip-flops in the SSPIF synchroniser; minimum 2.
- LMS_EN, 1, 1 = run the weight-update phase; 0 = skip it.

Ports:
- Clk_100M  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- SSPIF  in  1  sample-ready flag from the SPI block; asynchronous to Clk_100M.
- Enable  in  1  1 = accept new sample requests.
- OverrunClr  in  1  synchronous clear for Overrun.
- RAMDataEN  out  1  one-cycle write strobe for the new sample.
- RAMWrAddr  out  ADDR_W  circular write pointer.
- TapAddr  out  ADDR_W  delay-line read address during the MAC and UPD phases.
- AccClr  out  1  one-cycle accumulator clear.
- FilterEN  out  1  MAC enable, one tap per cycle.
- UpdateEN  out  1  LMS update enable, one tap per cycle.
- DACLoad  out  1  one-cycle DAC output strobe.
- Busy  out  1  high whenever the state is not IDLE.
- Overrun  out  1  sticky; a sample arrived while Busy.

Behaviour:
- Reset values (Reset=0, applied immediately, asynchronous):
  - all strobes 0, RAMWrAddr=0, TapAddr=0, Overrun=0, state=IDLE.
  - synchroniser and edge-detect flops cleared to 0.
- Sample request:
  - SSPIF passes through SYNC_STAGES flops, then a rising-edge detector produces a one-cycle sample_req.
  - If SSPIF is already high at reset release, that counts as one rising edge.
- States: IDLE, WRITE, CLR, MAC, UPD, OUT.
  - IDLE: on sample_req with Enable=1, go to WRITE. With Enable=0 the request is dropped silently and Overrun is unaffected.
  - WRITE (1 cycle): RAMDataEN=1 while RAMWrAddr=p. Latch newest=p. RAMWrAddr becomes p+1 mod TAPS on exit; wrap 31->0 is natural with ADDR_W bits. Go to CLR.
  - CLR (1 cycle): AccClr=1, tap counter k=0. Go to MAC.
  - MAC (TAPS cycles): FilterEN=1, TapAddr=(newest-k) mod TAPS, k increments each cycle. After k=TAPS-1: go to UPD if LMS_EN=1, else OUT.
  - UPD (TAPS cycles, LMS_EN=1 only): UpdateEN=1, TapAddr follows the same sequence with k restarted at 0. Go to OUT.
  - OUT (1 cycle): DACLoad=1. Go to IDLE.
- Strobes are registered outputs and mutually exclusive. TapAddr holds its last value outside MAC/UPD.
- Latency: the first SSPIF rise seen by the clock gives RAMDataEN SYNC_STAGES+1 cycles later.
- Busy duration: 2*TAPS+3 cycles with LMS_EN=1, TAPS+3 with LMS_EN=0.
- Overrun:
  - sample_req while state!=IDLE sets Overrun; that request is discarded, never queued.
  - OverrunClr=1 clears Overrun. If set and clear occur in the same cycle, set wins.
- Enable deasserted mid-frame: the current frame completes normally; only new requests are blocked.
- Reset mid-frame: the frame is aborted, outputs return to reset values, and no DACLoad is issued.
- SSPIF held high for many cycles produces exactly one request; it must return low for at least one synchronised cycle to re-arm.

Test Plan:
- Reset low 220 ns, then high; SSPIF pulse 500 ns, Enable=1, TAPS=32, LMS_EN=1 -> RAMDataEN once at SYNC_STAGES+1 cycles after the first sampled high, RAMWrAddr=0 during the strobe then 1; AccClr once; FilterEN for 32 cycles with TapAddr 0,31,30,...,1; UpdateEN for 32 cycles with the same sequence; DACLoad once; Busy high for exactly 67 cycles.
- 33 well-spaced SSPIF pulses -> RAMWrAddr during the strobe runs 0..31 then 0; on frame 33, MAC TapAddr starts at 0, 31, ...
- Second SSPIF rise 20 cycles into a frame -> Overrun=1, no extra RAMDataEN, current frame unchanged. OverrunClr pulsed -> Overrun=0. OverrunClr on the same cycle as a new overrun -> Overrun stays 1.
- Reset pulled low during the MAC phase (k=10) -> all outputs 0 immediately, no DACLoad; next SSPIF starts a clean frame at RAMWrAddr=0.
- LMS_EN=0 build -> UpdateEN never asserted; DACLoad on the cycle after the 32nd FilterEN; Busy high for 35 cycles.
- Enable=0 with SSPIF pulse -> no strobes, Busy=0, Overrun=0. Enable dropped mid-frame -> frame completes including DACLoad.

Source files
------------

// File: rtl/anc_frame_scheduler.sv
// Per-sample sequencer for the ANC datapath: delay-line write, accumulator clear,
// FIR MAC sweep, optional LMS update sweep, then DAC load, with overrun detection.
module anc_frame_scheduler #(
  parameter int TAPS        = 32,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2,
  parameter int LMS_EN      = 1
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic              SSPIF,
  input  logic              Enable,
  input  logic              OverrunClr,
  output logic              RAMDataEN,
  output logic [ADDR_W-1:0] RAMWrAddr,
  output logic [ADDR_W-1:0] TapAddr,
  output logic              AccClr,
  output logic              FilterEN,
  output logic              UpdateEN,
  output logic              DACLoad,
  output logic              Busy,
  output logic              Overrun
);

  typedef enum logic [2:0] {IDLE, WRITE, CLR, MAC, UPD, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   sample_req;
  logic [ADDR_W-1:0]      newest;
  logic [ADDR_W-1:0]      k;

  // Request is registered after the edge detector, so the write strobe lands
  // SYNC_STAGES+1 cycles after the first clock edge that samples SSPIF high.
  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      sync       <= '0;
      sync_prev  <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], SSPIF};
      sync_prev  <= sync[SYNC_STAGES-1];
      sample_req <= sync[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      RAMDataEN <= 1'b0;
      RAMWrAddr <= '0;
      TapAddr   <= '0;
      AccClr    <= 1'b0;
      FilterEN  <= 1'b0;
      UpdateEN  <= 1'b0;
      DACLoad   <= 1'b0;
      Overrun   <= 1'b0;
      newest    <= '0;
      k         <= '0;
    end else begin
      RAMDataEN <= 1'b0;
      AccClr    <= 1'b0;
      FilterEN  <= 1'b0;
      UpdateEN  <= 1'b0;
      DACLoad   <= 1'b0;

      // Set has priority over clear so a fresh overrun is never lost.
      if (sample_req && state != IDLE) begin
        Overrun <= 1'b1;
      end else if (OverrunClr) begin
        Overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sample_req && Enable) begin
            state     <= WRITE;
            RAMDataEN <= 1'b1;
          end
        end
        WRITE: begin
          newest    <= RAMWrAddr;
          RAMWrAddr <= RAMWrAddr + 1'b1;
          AccClr    <= 1'b1;
          k         <= '0;
          state     <= CLR;
        end
        CLR: begin
          FilterEN <= 1'b1;
          TapAddr  <= newest;
          k        <= '0;
          state    <= MAC;
        end
        MAC: begin
          if (k == LAST_TAP) begin
            if (LMS_EN != 0) begin
              UpdateEN <= 1'b1;
              TapAddr  <= newest;
              k        <= '0;
              state    <= UPD;
            end else begin
              DACLoad <= 1'b1;
              state   <= OUT;
            end
          end else begin
            FilterEN <= 1'b1;
            TapAddr  <= newest - (k + 1'b1);
            k        <= k + 1'b1;
          end
        end
        UPD: begin
          if (k == LAST_TAP) begin
            DACLoad <= 1'b1;
            state   <= OUT;
          end else begin
            UpdateEN <= 1'b1;
            TapAddr  <= newest - (k + 1'b1);
            k        <= k + 1'b1;
          end
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule
